// File: rtl/norm_shift_pipe.sv
// Two-stage post-add normaliser: stage 1 registers the operands with a leading-zero count,
// stage 2 registers the shifted mantissa, adjusted exponent and flags. Optional exp_ovf/exp_unf
// outputs are enabled by defining NORM_EXC_FLAGS_EN.
module norm_shift_pipe #(
   parameter int unsigned MANT_W = 27,
   parameter int unsigned EXP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W-1:0] adder_out,
   input  logic              ovf,
   input  logic [EXP_W-1:0]  exp_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] mant_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic              zero_out
`ifdef NORM_EXC_FLAGS_EN
   ,
   output logic              exp_ovf,
   output logic              exp_unf
`endif
);

   localparam int unsigned LZC_W = $clog2(MANT_W + 1);

   logic              r_v1;
   logic              r_v2;
   logic [MANT_W-1:0] r_mant1;
   logic              r_ovf1;
   logic [EXP_W-1:0]  r_exp1;
   logic [LZC_W-1:0]  r_lzc1;

   logic              w_s1_load;
   logic              w_s2_load;
   logic [LZC_W-1:0]  w_lzc;
   logic [EXP_W:0]    w_sum;
   logic              w_sat;
   logic              w_clamp;
   logic [31:0]       w_lzc_ext;
   logic [31:0]       w_exp_ext;
   logic [31:0]       w_shamt;
   logic [MANT_W-1:0] w_mant;
   logic [EXP_W-1:0]  w_exp;
   logic              w_zero;

   assign w_s2_load = !r_v2 || out_ready;
   assign w_s1_load = !r_v1 || w_s2_load;
   assign in_ready  = w_s1_load;
   assign out_valid = r_v2;

   // Highest set bit is visited last and wins; all-zero input leaves MANT_W.
   always_comb begin
      w_lzc = LZC_W'(MANT_W);
      for (int i = 0; i < MANT_W; i++) begin
         if (adder_out[i]) w_lzc = LZC_W'(MANT_W - 1 - i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_mant1 <= '0;
         r_ovf1  <= 1'b0;
         r_exp1  <= '0;
         r_lzc1  <= '0;
      end else if (w_s1_load) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_mant1 <= adder_out;
            r_ovf1  <= ovf;
            r_exp1  <= exp_in;
            r_lzc1  <= w_lzc;
         end
      end
   end

   assign w_sum     = {1'b0, r_exp1} + (EXP_W + 1)'(1);
   assign w_sat     = w_sum >= {1'b0, {EXP_W{1'b1}}};
   assign w_lzc_ext = 32'(r_lzc1);
   assign w_exp_ext = 32'(r_exp1);
   // Shift is limited by the exponent so the result goes subnormal instead of negative.
   assign w_clamp   = w_lzc_ext >= w_exp_ext;
   assign w_shamt   = w_clamp ? w_exp_ext : w_lzc_ext;

   always_comb begin
      w_mant = r_mant1;
      w_exp  = r_exp1;
      w_zero = 1'b0;
      if (r_ovf1) begin
         w_mant = {1'b1, r_mant1[MANT_W-1:2], r_mant1[1] | r_mant1[0]};
         w_exp  = w_sat ? {EXP_W{1'b1}} : w_sum[EXP_W-1:0];
      end else if (!r_mant1[MANT_W-1]) begin
         if (r_mant1 == '0) begin
            w_mant = '0;
            w_exp  = '0;
            w_zero = 1'b1;
         end else begin
            w_mant = r_mant1 << w_shamt;
            w_exp  = w_clamp ? '0 : EXP_W'(w_exp_ext - w_lzc_ext);
         end
      end
   end

`ifdef NORM_EXC_FLAGS_EN
   logic w_exp_ovf;
   logic w_exp_unf;
   assign w_exp_ovf = r_ovf1 && w_sat;
   assign w_exp_unf = !r_ovf1 && !r_mant1[MANT_W-1] && (r_mant1 != '0) && w_clamp;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v2     <= 1'b0;
         mant_out <= '0;
         exp_out  <= '0;
         zero_out <= 1'b0;
`ifdef NORM_EXC_FLAGS_EN
         exp_ovf  <= 1'b0;
         exp_unf  <= 1'b0;
`endif
      end else if (w_s2_load) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            mant_out <= w_mant;
            exp_out  <= w_exp;
            zero_out <= w_zero;
`ifdef NORM_EXC_FLAGS_EN
            exp_ovf  <= w_exp_ovf;
            exp_unf  <= w_exp_unf;
`endif
         end
      end
   end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Randomised scoreboard bench for norm_shift_pipe (MANT_W=27, EXP_W=8) with directed
// corner beats, backpressure, throughput and mid-flight reset scenarios.
module tb_norm_shift_pipe;

   localparam int unsigned MANT_W = 27;
   localparam int unsigned EXP_W  = 8;

   typedef struct packed {
      logic [MANT_W-1:0] mant;
      logic [EXP_W-1:0]  expo;
      logic              zero;
      logic              eovf;
      logic              eunf;
   } res_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [MANT_W-1:0] adder_out;
   logic              ovf;
   logic [EXP_W-1:0]  exp_in;
   logic              out_valid;
   logic              out_ready;
   logic [MANT_W-1:0] mant_out;
   logic [EXP_W-1:0]  exp_out;
   logic              zero_out;
`ifdef NORM_EXC_FLAGS_EN
   logic              exp_ovf;
   logic              exp_unf;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_acc    = 0;
   int   n_out    = 0;
   res_t exp_q[$];

   norm_shift_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .adder_out (adder_out),
      .ovf       (ovf),
      .exp_in    (exp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mant_out  (mant_out),
      .exp_out   (exp_out),
      .zero_out  (zero_out)
`ifdef NORM_EXC_FLAGS_EN
      ,
      .exp_ovf   (exp_ovf),
      .exp_unf   (exp_unf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_checks++;
      if (obs !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, req);
      end
   endtask

   // Normalise one bit at a time until the MSB is set or the exponent bottoms out.
   function automatic res_t model(input logic [MANT_W-1:0] a, input logic o,
                                  input logic [EXP_W-1:0] e);
      res_t              r;
      logic [MANT_W-1:0] m;
      int unsigned       ee;
      r.zero = 1'b0;
      r.eovf = 1'b0;
      r.eunf = 1'b0;
      if (o) begin
         m  = (27'h1 << 26) | (a >> 1) | (a & 27'h1);
         ee = e + 1;
         if (ee >= 255) begin
            ee     = 255;
            r.eovf = 1'b1;
         end
      end else if (a == 0) begin
         m      = '0;
         ee     = 0;
         r.zero = 1'b1;
      end else begin
         m  = a;
         ee = e;
         if (!m[MANT_W-1]) begin
            while (!m[MANT_W-1] && ee > 0) begin
               m  = m << 1;
               ee = ee - 1;
            end
            if (ee == 0) r.eunf = 1'b1;
         end
      end
      r.mant = m;
      r.expo = ee[EXP_W-1:0];
      return r;
   endfunction

   task automatic rand_beat(output logic [MANT_W-1:0] a, output logic o,
                            output logic [EXP_W-1:0] e);
      a = MANT_W'($urandom);
      a = a >> $urandom_range(0, 26);
      if ($urandom_range(0, 15) == 0) a = '0;
      o = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
         0:       e = EXP_W'($urandom_range(0, 30));
         1:       e = EXP_W'($urandom_range(240, 255));
         default: e = EXP_W'($urandom);
      endcase
   endtask

   // One cycle: score handshakes at the falling edge, then step to just after the rising edge.
   task automatic tick();
      res_t r;
      @(negedge clk);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("stale_out", {63'd0, out_valid}, 64'd0);
         end else begin
            r = exp_q[0];
            check("sb_mant", 64'(mant_out), 64'(r.mant));
            check("sb_exp", 64'(exp_out), 64'(r.expo));
            check("sb_zero", 64'(zero_out), 64'(r.zero));
`ifdef NORM_EXC_FLAGS_EN
            check("sb_eovf", 64'(exp_ovf), 64'(r.eovf));
            check("sb_eunf", 64'(exp_unf), 64'(r.eunf));
`endif
            if (out_ready) begin
               void'(exp_q.pop_front());
               n_out++;
            end
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(adder_out, ovf, exp_in));
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         tick();
      end
      check("drain_q", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic directed(input string tag, input logic [MANT_W-1:0] a, input logic o,
                           input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] req_m,
                           input logic [EXP_W-1:0] req_e, input logic req_z,
                           input logic req_ovf, input logic req_unf);
      in_valid  = 1'b1;
      adder_out = a;
      ovf       = o;
      exp_in    = e;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_mant"}, 64'(mant_out), 64'(req_m));
      check({tag, "_exp"}, 64'(exp_out), 64'(req_e));
      check({tag, "_zero"}, 64'(zero_out), 64'(req_z));
`ifdef NORM_EXC_FLAGS_EN
      check({tag, "_eovf"}, 64'(exp_ovf), 64'(req_ovf));
      check({tag, "_eunf"}, 64'(exp_unf), 64'(req_unf));
`else
      if (req_ovf || req_unf) n_checks += 0;
`endif
      tick();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [MANT_W-1:0] bp_a[4];
      logic              bp_o[4];
      logic [EXP_W-1:0]  bp_e[4];
      int                acc0;
      int                out0;
      int                k;

      rst       = 1'b1;
      in_valid  = 1'b0;
      adder_out = '0;
      ovf       = 1'b0;
      exp_in    = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_mant", 64'(mant_out), 64'd0);
      check("rst_exp", 64'(exp_out), 64'd0);
      check("rst_zero", 64'(zero_out), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      directed("lshift", 27'h0400000, 1'b0, 8'd100, 27'h4000000, 8'd96, 1'b0, 1'b0, 1'b0);
      directed("rshift", 27'h0000003, 1'b1, 8'd10, 27'h4000001, 8'd11, 1'b0, 1'b0, 1'b0);
      directed("unf", 27'h0000100, 1'b0, 8'd5, 27'h0002000, 8'd0, 1'b0, 1'b0, 1'b1);
      directed("ovf", 27'h0000004, 1'b1, 8'd254, 27'h4000002, 8'd255, 1'b0, 1'b1, 1'b0);
      directed("zero", 27'h0000000, 1'b0, 8'd77, 27'h0000000, 8'd0, 1'b1, 1'b0, 1'b0);
      directed("pass", 27'h5234567, 1'b0, 8'd0, 27'h5234567, 8'd0, 1'b0, 1'b0, 1'b0);
      directed("exact", 27'h0100000, 1'b0, 8'd6, 27'h4000000, 8'd0, 1'b0, 1'b0, 1'b1);
      drain();

      // Backpressure: four beats offered against a stalled output.
      for (int i = 0; i < 4; i++) rand_beat(bp_a[i], bp_o[i], bp_e[i]);
      out_ready = 1'b0;
      acc0      = n_acc;
      out0      = n_out;
      k         = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid  = 1'b1;
         adder_out = bp_a[k];
         ovf       = bp_o[k];
         exp_in    = bp_e[k];
         tick();
         k = n_acc - acc0;
      end
      check("bp_accepted", 64'(n_acc - acc0), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (k >= 4 && exp_q.size() == 0 && !out_valid) break;
         in_valid = (k < 4);
         if (k < 4) begin
            adder_out = bp_a[k];
            ovf       = bp_o[k];
            exp_in    = bp_e[k];
         end
         tick();
         k = n_acc - acc0;
      end
      in_valid = 1'b0;
      check("bp_emerged", 64'(n_out - out0), 64'd4);

      // Full-rate streaming.
      acc0 = n_acc;
      for (int c = 0; c < 20; c++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         rand_beat(adder_out, ovf, exp_in);
         tick();
      end
      check("tput_acc", 64'(n_acc - acc0), 64'd20);
      drain();

      for (int c = 0; c < 2000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         rand_beat(adder_out, ovf, exp_in);
         tick();
      end
      drain();

      // Reset with two beats stuck in the pipe.
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1;
         rand_beat(adder_out, ovf, exp_in);
         tick();
      end
      in_valid = 1'b0;
      check("mid_full", 64'(out_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mid_next_valid", 64'(out_valid), 64'd0);
      check("mid_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      out0      = n_out;
      for (int c = 0; c < 10; c++) tick();
      check("mid_no_stale", 64'(n_out - out0), 64'd0);
      directed("after_rst", 27'h0000001, 1'b0, 8'd200, 27'h4000000, 8'd174, 1'b0, 1'b0,
               1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/norm_shift_pipe.md
NORM_SHIFT_PIPE -- requirements
Module: norm_shift_pipe

Interface
REQ-001 SHALL have parameter MANT_W, default 27, adder-result mantissa width including guard/sticky bits (min 4).
REQ-002 SHALL have parameter EXP_W, default 8, exponent width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port adder_out  input  MANT_W  unnormalised adder mantissa.
REQ-008 SHALL have port ovf  input  1  adder carry-out.
REQ-009 SHALL have port exp_in  input  EXP_W  pre-normalisation exponent.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port mant_out  output  MANT_W  normalised mantissa.
REQ-013 SHALL have port exp_out  output  EXP_W  adjusted exponent.
REQ-014 SHALL have port zero_out  output  1  result is exact zero.

Function
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers inputs plus leading-zero count (lzc) of adder_out; stage 2 registers shifted mantissa, exponent and flags; latency 2 cycles with no stall.
REQ-016 SHALL, when ovf=1, output {1'b1, adder_out[MANT_W-1:2], adder_out[1]|adder_out[0]} and exp_in+1.
REQ-017 SHALL, when ovf=0 and adder_out[MANT_W-1]=1, pass adder_out and exp_in unchanged.
REQ-018 SHALL, when ovf=0, MSB=0 and adder_out nonzero, left-shift by s=min(lzc, exp_in), zero-filling, and output exp_in-s.
REQ-019 SHALL, when lzc>=exp_in on the left-shift path, output exp_out=0 and raise the underflow condition; a subnormal mantissa results.
REQ-020 SHALL, when ovf=0 and adder_out=0, output mant_out=0, exp_out=0, zero_out=1.
REQ-021 SHALL, when exp_in+1 >= 2^EXP_W-1 on the ovf path, saturate exp_out to all-ones and raise the overflow condition.
REQ-022 SHALL load stage 2 when it is empty or out_ready=1; SHALL load stage 1 when it is empty or stage 2 loads; in_ready = stage-1-empty OR stage-2-load.
REQ-023 SHALL accept an input only when in_valid=1 and in_ready=1, and transfer an output only when out_valid=1 and out_ready=1.
REQ-024 SHALL hold mant_out, exp_out, zero_out and flags stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain one result per cycle with out_ready held at 1; SHALL never drop or duplicate beats under any stall pattern.

Reset
REQ-026 SHALL, on rst=1, asynchronously clear both stage valids, mant_out, exp_out, zero_out and flags to 0.
REQ-027 SHALL discard in-flight beats when rst asserts mid-operation; in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with macro NORM_EXC_FLAGS_EN defined, add outputs exp_ovf (1) and exp_unf (1), registered in stage 2, valid with out_valid, reflecting REQ-021 and REQ-019.
REQ-029 SHALL, without NORM_EXC_FLAGS_EN, omit exp_ovf and exp_unf ports; datapath results remain identical.

Verification (MANT_W=27, EXP_W=8, NORM_EXC_FLAGS_EN defined)
REQ-030 SHALL cover left shift: adder_out=27'h0400000, ovf=0, exp_in=100 -> after 2 cycles mant_out=27'h4000000, exp_out=96, zero_out=0.
REQ-031 SHALL cover right shift with sticky: adder_out=27'h0000003, ovf=1, exp_in=10 -> mant_out=27'h4000001, exp_out=11.
REQ-032 SHALL cover underflow clamp: adder_out=27'h0000100, ovf=0, exp_in=5 -> mant_out=27'h0002000, exp_out=0, exp_unf=1.
REQ-033 SHALL cover overflow and zero: ovf=1, exp_in=254 -> exp_out=255, exp_ovf=1; then adder_out=0, ovf=0 -> zero_out=1, exp_out=0.
REQ-034 SHALL cover backpressure: 4 back-to-back inputs, out_ready=0 for 6 cycles -> exactly 2 accepted, in_ready=0, outputs held; on out_ready=1 all 4 emerge in order.
REQ-035 SHALL cover reset mid-flight: rst pulse with 2 beats in flight -> out_valid=0 next cycle, no stale result emerges afterward.
